load_store_unit: RTL and testbench

- Initiator-side controller for the byte-addressed data RAM (0x1000–0x1FFF).
- Translates CPU load/store requests (funct3-encoded LB/LH/LW/LBU/LHU/SB/SH/SW) into RAM port cycles.
- Performs read-modify-write for sub-word stores, because the RAM always writes 4 bytes.
- Returns sign/zero-extended load data and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundle of the CPU request/response handshake and the data RAM port of the load/store unit.
// The master side is the CPU plus RAM; the slave side is the load/store unit itself.
interface load_store_unit_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [31:0]              req_wdata;
  logic                     resp_valid;
  logic [31:0]              resp_rdata;
  logic                     resp_err;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_write_enable;
  logic [31:0]              mem_write_data;
  logic [31:0]              mem_read_data;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_write_enable, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store controller for the byte-addressed data RAM: sub-word stores are done as
// read-modify-write because the RAM only writes whole words; bad accesses never reach the RAM.
module load_store_unit #(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RAM_BASE    = 32'h00001000,
  parameter logic [ADDRESS_WIDTH-1:0] RAM_TOP     = 32'h00001fff
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [ADDRESS_WIDTH-1:0] RAM_LAST_WORD =
    RAM_TOP - {{(ADDRESS_WIDTH-2){1'b0}}, 2'b11};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic                     write_r, write_nxt_s;
  logic [2:0]               funct3_r, funct3_nxt_s;
  logic [1:0]               lane_r, lane_nxt_s;
  logic [31:0]              req_wdata_r, req_wdata_nxt_s;
  logic [ADDRESS_WIDTH-1:0] mem_address_r, mem_address_nxt_s;
  logic                     mem_write_enable_r, mem_write_enable_nxt_s;
  logic [31:0]              mem_write_data_r, mem_write_data_nxt_s;
  logic                     resp_valid_r, resp_valid_nxt_s;
  logic [31:0]              resp_rdata_r, resp_rdata_nxt_s;
  logic                     resp_err_r, resp_err_nxt_s;
  logic                     req_error_s;

  function automatic logic access_error(input logic                     write,
                                        input logic [2:0]               funct3,
                                        input logic [ADDRESS_WIDTH-1:0] addr);
    logic [ADDRESS_WIDTH-1:0] aligned;
    logic                     bad;
    aligned = {addr[ADDRESS_WIDTH-1:2], 2'b00};
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr[0];
      F3_W:    bad = (addr[1:0] != 2'b00);
      F3_BU:   bad = write;
      F3_HU:   bad = write | addr[0];
      default: bad = 1'b1;
    endcase
    bad = bad | (aligned < RAM_BASE) | (aligned > RAM_LAST_WORD);
    return bad;
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0]  funct3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] result;
    case (lane)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      2'd3:    sel_byte = word[31:24];
      default: sel_byte = 8'h00;
    endcase
    sel_half = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   result = {24'h000000, sel_byte};
      F3_H:    result = {{16{sel_half[15]}}, sel_half};
      F3_HU:   result = {16'h0000, sel_half};
      F3_W:    result = word;
      default: result = 32'h00000000;
    endcase
    return result;
  endfunction

  function automatic logic [31:0] merge_store(input logic [2:0]  funct3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] old_word,
                                              input logic [31:0] wdata);
    logic [31:0] merged;
    merged = old_word;
    case (funct3)
      F3_B: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          2'd3:    merged[31:24] = wdata[7:0];
          default: merged        = old_word;
        endcase
      end
      F3_H: begin
        if (lane[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      F3_W:    merged = wdata;
      default: merged = old_word;
    endcase
    return merged;
  endfunction

  assign req_error_s = access_error(bus.req_write, bus.req_funct3, bus.req_addr);

  // Next-state and next-register computation for the access sequencer.
  always_comb begin
    state_nxt_s            = state_r;
    write_nxt_s            = write_r;
    funct3_nxt_s           = funct3_r;
    lane_nxt_s             = lane_r;
    req_wdata_nxt_s        = req_wdata_r;
    mem_address_nxt_s      = mem_address_r;
    mem_write_enable_nxt_s = 1'b0;
    mem_write_data_nxt_s   = mem_write_data_r;
    resp_valid_nxt_s       = 1'b0;
    resp_rdata_nxt_s       = resp_rdata_r;
    resp_err_nxt_s         = resp_err_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_nxt_s     = bus.req_write;
          funct3_nxt_s    = bus.req_funct3;
          lane_nxt_s      = bus.req_addr[1:0];
          req_wdata_nxt_s = bus.req_wdata;
          if (req_error_s) begin
            state_nxt_s      = ST_RESP;
            resp_valid_nxt_s = 1'b1;
            resp_err_nxt_s   = 1'b1;
            resp_rdata_nxt_s = 32'h00000000;
          end else if (!bus.req_write) begin
            state_nxt_s       = ST_LOAD;
            mem_address_nxt_s = {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
          end else if (bus.req_funct3 == F3_W) begin
            // Full-word stores skip the read and go straight to the write cycle.
            state_nxt_s            = ST_WRITE;
            mem_address_nxt_s      = {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
            mem_write_enable_nxt_s = 1'b1;
            mem_write_data_nxt_s   = bus.req_wdata;
          end else begin
            state_nxt_s       = ST_RMW_READ;
            mem_address_nxt_s = {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s      = ST_RESP;
        resp_valid_nxt_s = 1'b1;
        resp_err_nxt_s   = 1'b0;
        resp_rdata_nxt_s = extend_load(funct3_r, lane_r, bus.mem_read_data);
      end
      ST_RMW_READ: begin
        state_nxt_s            = ST_WRITE;
        mem_write_enable_nxt_s = 1'b1;
        mem_write_data_nxt_s   = merge_store(funct3_r, lane_r, bus.mem_read_data, req_wdata_r);
      end
      ST_WRITE: begin
        state_nxt_s      = ST_RESP;
        resp_valid_nxt_s = 1'b1;
        resp_err_nxt_s   = 1'b0;
        resp_rdata_nxt_s = 32'h00000000;
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any access in flight, including its write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= ST_IDLE;
      write_r            <= 1'b0;
      funct3_r           <= 3'b000;
      lane_r             <= 2'b00;
      req_wdata_r        <= 32'h00000000;
      mem_address_r      <= '0;
      mem_write_enable_r <= 1'b0;
      mem_write_data_r   <= 32'h00000000;
      resp_valid_r       <= 1'b0;
      resp_rdata_r       <= 32'h00000000;
      resp_err_r         <= 1'b0;
    end else begin
      state_r            <= state_nxt_s;
      write_r            <= write_nxt_s;
      funct3_r           <= funct3_nxt_s;
      lane_r             <= lane_nxt_s;
      req_wdata_r        <= req_wdata_nxt_s;
      mem_address_r      <= mem_address_nxt_s;
      mem_write_enable_r <= mem_write_enable_nxt_s;
      mem_write_data_r   <= mem_write_data_nxt_s;
      resp_valid_r       <= resp_valid_nxt_s;
      resp_rdata_r       <= resp_rdata_nxt_s;
      resp_err_r         <= resp_err_nxt_s;
    end
  end

  assign bus.req_ready        = rst_n & (state_r == ST_IDLE);
  assign bus.mem_address      = mem_address_r;
  assign bus.mem_write_enable = mem_write_enable_r;
  assign bus.mem_write_data   = mem_write_data_r;
  assign bus.resp_valid       = resp_valid_r;
  assign bus.resp_rdata       = resp_rdata_r;
  assign bus.resp_err         = resp_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses against a word RAM model,
// plus hand sequences for reset behaviour and an access aborted by reset.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   wr_count;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic [31:0] ram [0:1023];

  load_store_unit_if #(.ADDRESS_WIDTH(32)) bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_writes;
    logic [31:0] exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_read_data = ram[bus.mem_address[11:2]];

  always @(posedge clk) begin
    if (bus.mem_write_enable) begin
      ram[bus.mem_address[11:2]] <= bus.mem_write_data;
      wr_count     <= wr_count + 1;
      last_wr_addr <= bus.mem_address;
      last_wr_data <= bus.mem_write_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee, input int el, input int ew,
                     input logic [31:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.write = w; v.f3 = f3; v.addr = a; v.wdata = d;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_writes = ew;
    v.exp_wa = ewa; v.exp_wd = ewd;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic apply(input int idx, input vec_t v);
    int    lat;
    int    w0;
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    wait_ready(nm);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.write;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    w0 = wr_count;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat++;
    end while (!bus.resp_valid && lat < 10);
    check({nm, "_latency"}, lat, v.exp_lat);
    check({nm, "_rdata"}, bus.resp_rdata, v.exp_rdata);
    check({nm, "_err"}, {31'd0, bus.resp_err}, {31'd0, v.exp_err});
    check({nm, "_writes"}, wr_count - w0, v.exp_writes);
    if (v.exp_writes > 0) begin
      check({nm, "_wr_addr"}, last_wr_addr, v.exp_wa);
      check({nm, "_wr_data"}, last_wr_data, v.exp_wd);
    end
    @(negedge clk);
    check({nm, "_pulse_len"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    wr_count = 0;
    last_wr_addr = 32'h0;
    last_wr_data = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;

    //   wr    f3      addr          wdata         rdata         err  lat wr  wr_addr       wr_data
    add(1'b1, 3'b010, 32'h00001004, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1, 32'h00001004, 32'hDEADBEEF);
    add(1'b0, 3'b010, 32'h00001004, 32'h00000000, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0, 32'h0);
    add(1'b1, 3'b010, 32'h00001008, 32'h11223344, 32'h00000000, 1'b0, 2, 1, 32'h00001008, 32'h11223344);
    add(1'b1, 3'b000, 32'h0000100A, 32'h000000AB, 32'h00000000, 1'b0, 3, 1, 32'h00001008, 32'h11AB3344);
    add(1'b0, 3'b000, 32'h0000100A, 32'h00000000, 32'hFFFFFFAB, 1'b0, 2, 0, 32'h0, 32'h0);
    add(1'b0, 3'b100, 32'h0000100A, 32'h00000000, 32'h000000AB, 1'b0, 2, 0, 32'h0, 32'h0);
    add(1'b1, 3'b010, 32'h0000100C, 32'h55667788, 32'h00000000, 1'b0, 2, 1, 32'h0000100C, 32'h55667788);
    add(1'b1, 3'b001, 32'h0000100E, 32'h00008001, 32'h00000000, 1'b0, 3, 1, 32'h0000100C, 32'h80017788);
    add(1'b0, 3'b001, 32'h0000100E, 32'h00000000, 32'hFFFF8001, 1'b0, 2, 0, 32'h0, 32'h0);
    add(1'b0, 3'b101, 32'h0000100E, 32'h00000000, 32'h00008001, 1'b0, 2, 0, 32'h0, 32'h0);
    add(1'b0, 3'b010, 32'h00001008, 32'h00000000, 32'h11AB3344, 1'b0, 2, 0, 32'h0, 32'h0);
    add(1'b0, 3'b010, 32'h0000100C, 32'h00000000, 32'h80017788, 1'b0, 2, 0, 32'h0, 32'h0);
    add(1'b1, 3'b010, 32'h00001FFC, 32'h0A0B0C0D, 32'h00000000, 1'b0, 2, 1, 32'h00001FFC, 32'h0A0B0C0D);
    add(1'b0, 3'b100, 32'h00001FFF, 32'h00000000, 32'h0000000A, 1'b0, 2, 0, 32'h0, 32'h0);
    add(1'b1, 3'b000, 32'h00001FFF, 32'h000000F0, 32'h00000000, 1'b0, 3, 1, 32'h00001FFC, 32'hF00B0C0D);
    add(1'b0, 3'b000, 32'h00001FFF, 32'h00000000, 32'hFFFFFFF0, 1'b0, 2, 0, 32'h0, 32'h0);
    add(1'b0, 3'b010, 32'h00001FFC, 32'h00000000, 32'hF00B0C0D, 1'b0, 2, 0, 32'h0, 32'h0);
    add(1'b0, 3'b010, 32'h00001002, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0);
    add(1'b1, 3'b001, 32'h00001001, 32'h00001234, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0);
    add(1'b0, 3'b010, 32'h00002000, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0);
    add(1'b0, 3'b000, 32'h00000FFF, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0);
    add(1'b0, 3'b011, 32'h00001000, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0);
    add(1'b1, 3'b100, 32'h00001000, 32'h000000FF, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0);
    add(1'b0, 3'b001, 32'h00001003, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0);
    add(1'b1, 3'b010, 32'h00002000, 32'h12345678, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0);
    add(1'b0, 3'b010, 32'h00000FFC, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0);

    // Reset and idle state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready_low", {31'd0, bus.req_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    check("idle_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("idle_we", {31'd0, bus.mem_write_enable}, 32'd0);
    check("idle_addr", bus.mem_address, 32'h0);
    check("idle_wdata", bus.mem_write_data, 32'h0);
    check("idle_rdata", bus.resp_rdata, 32'h0);
    check("idle_err", {31'd0, bus.resp_err}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // Reset arriving during the read half of a byte store must not let the write through.
    add(1'b1, 3'b010, 32'h00001010, 32'hCAFEF00D, 32'h00000000, 1'b0, 2, 1, 32'h00001010, 32'hCAFEF00D);
    apply(100, vecs[vecs.size()-1]);
    begin
      int w0;
      @(negedge clk);
      wait_ready("abort");
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h00001010;
      bus.req_wdata  = 32'h00000077;
      w0 = wr_count;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("abort_in_rmw_ready", {31'd0, bus.req_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort_we_low", {31'd0, bus.mem_write_enable}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_no_write", wr_count - w0, 32'd0);
      check("abort_ram_word", ram[10'h004], 32'hCAFEF00D);
      check("abort_idle_ready", {31'd0, bus.req_ready}, 32'd1);
      check("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    end
    add(1'b0, 3'b010, 32'h00001010, 32'h00000000, 32'hCAFEF00D, 1'b0, 2, 0, 32'h0, 32'h0);
    apply(101, vecs[vecs.size()-1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
